// File: rtl/exe_lane_cfg_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// exe_lane_cfg_ctrl_pkg
// Shared types and defaults for the execution-lane reconfiguration controller.
//   laneCfgState_t : sequencer states
//   laneCfgPkt_t   : lane / simple-ALU / complex-ALU mask bundle (default width)
//   cnt_width()    : width of a saturating counter covering all count limits
// ----------------------------------------------------------------------------
package exe_lane_cfg_ctrl_pkg;

  localparam int unsigned ISSUE_WIDTH_DEF    = 4;
  localparam int unsigned DRAIN_CYCLES_DEF   = 4;  // RR, RR/EXE, EXE, WB
  localparam int unsigned SETTLE_CYCLES_DEF  = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    APPLY,
    SETTLE,
    ACK
  } laneCfgState_t;

  typedef struct packed {
    logic [ISSUE_WIDTH_DEF-1:0] lane;
    logic [ISSUE_WIDTH_DEF-1:0] salu;
    logic [ISSUE_WIDTH_DEF-1:0] calu;
  } laneCfgPkt_t;

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/exe_lane_cfg_satcnt.sv
// ----------------------------------------------------------------------------
// exe_lane_cfg_satcnt
// Saturating up-counter with synchronous clear and enable.
//   clk    : clock
//   reset  : asynchronous active-low reset (count -> 0)
//   clr_i  : clear to 0 (has priority over enable)
//   en_i   : count up by one, holding at MAX
//   hit_o  : the count after this cycle equals MAX (and no clear)
// ----------------------------------------------------------------------------
module exe_lane_cfg_satcnt #(
  parameter int unsigned W   = 3,
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != W'(MAX)))
      cnt_d = cnt_q + 1'b1;
  end

  // Looks at the post-increment value so the owner can leave its state in the
  // same cycle the limit is reached.
  assign hit_o = !clr_i && (cnt_d == W'(MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/exe_lane_cfg_ctrl.sv
// ----------------------------------------------------------------------------
// exe_lane_cfg_ctrl
// Sequences dynamic reconfiguration of the execution lanes: stall issue, drain
// the pipes, apply the new lane/SALU/CALU masks, wait for the clock-gate enables
// to settle, then acknowledge.
// Optional feature macro: DRAIN_TIMEOUT_EN (drain watchdog + cfgTimeout_o).
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   cfgReq_i              : one-cycle request pulse, honoured only in IDLE
//   cfgLaneMask_i         : requested lane-active mask (bit 0 forced on)
//   cfgSaluMask_i         : requested simple-ALU mask (ANDed with lane)
//   cfgCaluMask_i         : requested complex-ALU mask (ANDed with lane)
//   pipeBusy_i            : per-lane in-flight indication
//   recoverFlag_i         : pipeline flush; ends DRAIN immediately
//   issueStall_o          : registered, blocks issue selection
//   laneActive_o          : registered lane-active mask
//   saluLaneActive_o      : registered simple-ALU mask
//   caluLaneActive_o      : registered complex-ALU mask
//   cfgBusy_o             : state != IDLE (combinational)
//   cfgAck_o              : registered one-cycle ack
//   cfgTimeout_o          : (DRAIN_TIMEOUT_EN) one-cycle watchdog pulse
// ----------------------------------------------------------------------------
module exe_lane_cfg_ctrl
  import exe_lane_cfg_ctrl_pkg::*;
#(
  parameter int unsigned ISSUE_WIDTH    = ISSUE_WIDTH_DEF,
  parameter int unsigned DRAIN_CYCLES   = DRAIN_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfgReq_i,
  input  logic [ISSUE_WIDTH-1:0] cfgLaneMask_i,
  input  logic [ISSUE_WIDTH-1:0] cfgSaluMask_i,
  input  logic [ISSUE_WIDTH-1:0] cfgCaluMask_i,
  input  logic [ISSUE_WIDTH-1:0] pipeBusy_i,
  input  logic                   recoverFlag_i,
  output logic                   issueStall_o,
  output logic [ISSUE_WIDTH-1:0] laneActive_o,
  output logic [ISSUE_WIDTH-1:0] saluLaneActive_o,
  output logic [ISSUE_WIDTH-1:0] caluLaneActive_o,
  output logic                   cfgBusy_o,
  output logic                   cfgAck_o
`ifdef DRAIN_TIMEOUT_EN
  ,
  output logic                   cfgTimeout_o
`endif
);

  localparam int unsigned CNT_W = cnt_width(DRAIN_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);

  typedef struct packed {
    logic [ISSUE_WIDTH-1:0] lane;
    logic [ISSUE_WIDTH-1:0] salu;
    logic [ISSUE_WIDTH-1:0] calu;
  } cfgPkt_t;

  laneCfgState_t state_q, state_d;
  cfgPkt_t       req_san;
  cfgPkt_t       pend_q, cur_q;
  logic          stall_d, ack_d;
  logic          stall_q, ack_q;
  logic          drain_hit, settle_hit;
  logic          in_drain, in_settle;

  assign in_drain  = (state_q == DRAIN);
  assign in_settle = (state_q == SETTLE);

  // Sanitised request: lane 0 always stays on, ALU masks limited to live lanes.
  always_comb begin
    req_san.lane    = cfgLaneMask_i;
    req_san.lane[0] = 1'b1;
    req_san.salu    = cfgSaluMask_i & req_san.lane;
    req_san.calu    = cfgCaluMask_i & req_san.lane;
  end

  exe_lane_cfg_satcnt #(.W(CNT_W), .MAX(DRAIN_CYCLES)) u_drain_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (!in_drain),
    .en_i  (in_drain),
    .hit_o (drain_hit)
  );

  exe_lane_cfg_satcnt #(.W(CNT_W), .MAX(SETTLE_CYCLES)) u_settle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (!in_settle),
    .en_i  (in_settle),
    .hit_o (settle_hit)
  );

`ifdef DRAIN_TIMEOUT_EN
  logic wd_hit;
  logic timeout_d, timeout_q;

  exe_lane_cfg_satcnt #(.W(CNT_W), .MAX(TIMEOUT_CYCLES)) u_wd_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (!in_drain),
    .en_i  (in_drain),
    .hit_o (wd_hit)
  );
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
`ifdef DRAIN_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (cfgReq_i)
          state_d = (req_san == cur_q) ? ACK : DRAIN;
      end
      DRAIN: begin
        if (recoverFlag_i || (drain_hit && (pipeBusy_i == '0)))
          state_d = APPLY;
`ifdef DRAIN_TIMEOUT_EN
        else if (wd_hit && (pipeBusy_i != '0)) begin
          state_d   = APPLY;
          timeout_d = 1'b1;
        end
`endif
      end
      APPLY:   state_d = SETTLE;
      SETTLE:  if (settle_hit) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; stall and ack are decoded from the next state and then
  // registered so they line up with the state they describe.
  always_comb begin
    cfgBusy_o = (state_q != IDLE);
    stall_d   = (state_d == DRAIN) || (state_d == APPLY) || (state_d == SETTLE);
    ack_d     = (state_d == ACK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= '0;
      cur_q   <= '1;
`ifdef DRAIN_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      stall_q <= stall_d;
      ack_q   <= ack_d;
      if ((state_q == IDLE) && cfgReq_i)
        pend_q <= req_san;
      if (state_q == APPLY)
        cur_q <= pend_q;
`ifdef DRAIN_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  assign issueStall_o     = stall_q;
  assign cfgAck_o         = ack_q;
  assign laneActive_o     = cur_q.lane;
  assign saluLaneActive_o = cur_q.salu;
  assign caluLaneActive_o = cur_q.calu;
`ifdef DRAIN_TIMEOUT_EN
  assign cfgTimeout_o     = timeout_q;
`endif

endmodule

// File: tb/tb_exe_lane_cfg_ctrl.sv
// ----------------------------------------------------------------------------
// tb_exe_lane_cfg_ctrl
// Directed testbench for exe_lane_cfg_ctrl. Cycle numbering: the request is
// sampled at the edge that starts cycle 1.
// Optional feature macro: DRAIN_TIMEOUT_EN.
// ----------------------------------------------------------------------------
module tb_exe_lane_cfg_ctrl;

  logic       clk;
  logic       reset;
  logic       cfgReq_i;
  logic [3:0] cfgLaneMask_i;
  logic [3:0] cfgSaluMask_i;
  logic [3:0] cfgCaluMask_i;
  logic [3:0] pipeBusy_i;
  logic       recoverFlag_i;
  logic       issueStall_o;
  logic [3:0] laneActive_o;
  logic [3:0] saluLaneActive_o;
  logic [3:0] caluLaneActive_o;
  logic       cfgBusy_o;
  logic       cfgAck_o;
`ifdef DRAIN_TIMEOUT_EN
  logic       cfgTimeout_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  exe_lane_cfg_ctrl #(
    .ISSUE_WIDTH   (4),
    .DRAIN_CYCLES  (4),
    .SETTLE_CYCLES (2),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cfgReq_i         (cfgReq_i),
    .cfgLaneMask_i    (cfgLaneMask_i),
    .cfgSaluMask_i    (cfgSaluMask_i),
    .cfgCaluMask_i    (cfgCaluMask_i),
    .pipeBusy_i       (pipeBusy_i),
    .recoverFlag_i    (recoverFlag_i),
    .issueStall_o     (issueStall_o),
    .laneActive_o     (laneActive_o),
    .saluLaneActive_o (saluLaneActive_o),
    .caluLaneActive_o (caluLaneActive_o),
    .cfgBusy_o        (cfgBusy_o),
    .cfgAck_o         (cfgAck_o)
`ifdef DRAIN_TIMEOUT_EN
    ,
    .cfgTimeout_o     (cfgTimeout_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Drive a one-cycle request; returns in cycle 1.
  task automatic do_req(input logic [3:0] lane, input logic [3:0] salu, input logic [3:0] calu);
    cfgReq_i      = 1'b1;
    cfgLaneMask_i = lane;
    cfgSaluMask_i = salu;
    cfgCaluMask_i = calu;
    tick();
    cfgReq_i      = 1'b0;
  endtask

  // Ticks until cfgAck_o is seen (bounded); reports how many ticks it took.
  task automatic wait_ack(input int max_ticks, output int n);
    n = 0;
    while (!cfgAck_o && n < max_ticks) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int acks;

    reset         = 1'b0;
    cfgReq_i      = 1'b0;
    cfgLaneMask_i = '0;
    cfgSaluMask_i = '0;
    cfgCaluMask_i = '0;
    pipeBusy_i    = '0;
    recoverFlag_i = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_lane",  32'(laneActive_o),     32'hF);
    check("rst_salu",  32'(saluLaneActive_o), 32'hF);
    check("rst_calu",  32'(caluLaneActive_o), 32'hF);
    check("rst_stall", 32'(issueStall_o),     32'h0);
    check("rst_busy",  32'(cfgBusy_o),        32'h0);
    check("rst_ack",   32'(cfgAck_o),         32'h0);
    reset = 1'b1;
    tick();

    // T1: basic sequence timing, no busy
    do_req(4'b0011, 4'b0011, 4'b0001);
    for (int c = 1; c <= 9; c++) begin
      check("t1_stall", 32'(issueStall_o), 32'((c >= 1) && (c <= 7)));
      check("t1_ack",   32'(cfgAck_o),     32'(c == 8));
      check("t1_lane",  32'(laneActive_o), (c >= 6) ? 32'h3 : 32'hF);
      if (c < 9) tick();
    end
    check("t1_salu", 32'(saluLaneActive_o), 32'h3);
    check("t1_calu", 32'(caluLaneActive_o), 32'h1);
    check("t1_idle", 32'(cfgBusy_o),        32'h0);

    // T2: request equal to current config -> immediate ack, no stall
    apply_reset();
    do_req(4'b1111, 4'b1111, 4'b1111);
    check("t2_ack1",   32'(cfgAck_o),     32'h1);
    check("t2_stall1", 32'(issueStall_o), 32'h0);
    check("t2_busy1",  32'(cfgBusy_o),    32'h1);
    tick();
    check("t2_ack2",   32'(cfgAck_o),     32'h0);
    check("t2_stall2", 32'(issueStall_o), 32'h0);
    check("t2_busy2",  32'(cfgBusy_o),    32'h0);
    check("t2_lane",   32'(laneActive_o), 32'hF);

    // T3: sanitising of an all-zero lane mask
    do_req(4'b0000, 4'b0000, 4'b1111);
    wait_ack(20, n);
    check("t3_ack_lat", 32'(n), 32'd7);
    check("t3_lane", 32'(laneActive_o),     32'h1);
    check("t3_salu", 32'(saluLaneActive_o), 32'h0);
    check("t3_calu", 32'(caluLaneActive_o), 32'h1);
    tick();

    // T4: busy held well past the drain minimum
    pipeBusy_i = 4'b0100;
    do_req(4'b1111, 4'b1111, 4'b1111);
    for (int c = 1; c <= 14; c++) begin
      check("t4_hold_lane",  32'(laneActive_o), 32'h1);
      check("t4_hold_stall", 32'(issueStall_o), 32'h1);
      tick();
    end
    pipeBusy_i = 4'b0000;                 // cycle 15
    check("t4_c15_lane", 32'(laneActive_o), 32'h1);
    tick();                               // cycle 16: APPLY
    check("t4_c16_lane",  32'(laneActive_o), 32'h1);
    check("t4_c16_stall", 32'(issueStall_o), 32'h1);
    tick();                               // cycle 17
    check("t4_c17_lane", 32'(laneActive_o), 32'hF);
    wait_ack(10, n);
    check("t4_ack_lat", 32'(n), 32'd2);
    tick();

    // T5: recovery flush ends DRAIN early; request during SETTLE ignored
    pipeBusy_i = 4'b1111;
    do_req(4'b0101, 4'b0001, 4'b0100);
    tick();                               // cycle 2
    recoverFlag_i = 1'b1;
    tick();                               // cycle 3: APPLY
    recoverFlag_i = 1'b0;
    check("t5_c3_lane",  32'(laneActive_o), 32'hF);
    check("t5_c3_stall", 32'(issueStall_o), 32'h1);
    tick();                               // cycle 4: SETTLE
    check("t5_lane", 32'(laneActive_o),     32'h5);
    check("t5_salu", 32'(saluLaneActive_o), 32'h1);
    check("t5_calu", 32'(caluLaneActive_o), 32'h4);
    pipeBusy_i = 4'b0000;
    do_req(4'b0011, 4'b0011, 4'b0011);    // cycle 5
    check("t5_c5_ack", 32'(cfgAck_o), 32'h0);
    tick();                               // cycle 6
    check("t5_c6_ack", 32'(cfgAck_o), 32'h1);
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (cfgAck_o) acks++;
    end
    check("t5_no_2nd_ack", 32'(acks), 32'd0);
    check("t5_lane_kept",  32'(laneActive_o), 32'h5);
    check("t5_stall_end",  32'(issueStall_o), 32'h0);

`ifdef DRAIN_TIMEOUT_EN
    // T6: watchdog forces APPLY with busy stuck
    pipeBusy_i = 4'b0010;
    do_req(4'b0011, 4'b0011, 4'b0011);
    for (int c = 1; c <= 63; c++) begin
      if (cfgTimeout_o) check("t6_early_to", 32'(c), 32'd0);
      tick();
    end
    check("t6_c64_to",   32'(cfgTimeout_o), 32'h0);
    check("t6_c64_lane", 32'(laneActive_o), 32'h5);
    tick();                               // cycle 65: APPLY
    check("t6_c65_to",   32'(cfgTimeout_o), 32'h1);
    tick();
    check("t6_c66_to",   32'(cfgTimeout_o), 32'h0);
    check("t6_c66_lane", 32'(laneActive_o), 32'h3);
    wait_ack(10, n);
    check("t6_ack_lat", 32'(n), 32'd2);
    pipeBusy_i = 4'b0000;
    tick();
`else
    // T6: without the watchdog, DRAIN waits for busy to clear
    pipeBusy_i = 4'b0010;
    do_req(4'b0011, 4'b0011, 4'b0011);
    acks = 0;
    for (int c = 1; c <= 80; c++) begin
      if (cfgAck_o) acks++;
      tick();
    end
    check("t6_no_ack",    32'(acks),         32'd0);
    check("t6_stall",     32'(issueStall_o), 32'h1);
    check("t6_lane_hold", 32'(laneActive_o), 32'h5);
    pipeBusy_i = 4'b0000;                 // cycle 81
    wait_ack(10, n);
    check("t6_ack_lat", 32'(n), 32'd4);
    check("t6_lane",    32'(laneActive_o), 32'h3);
    tick();
`endif

    // T7: asynchronous reset during SETTLE
    do_req(4'b0001, 4'b0001, 4'b0001);
    repeat (5) tick();                    // cycle 6: SETTLE
    check("t7_pre_lane", 32'(laneActive_o), 32'h1);
    reset = 1'b0;
    #1;
    check("t7_rst_lane",  32'(laneActive_o),     32'hF);
    check("t7_rst_salu",  32'(saluLaneActive_o), 32'hF);
    check("t7_rst_calu",  32'(caluLaneActive_o), 32'hF);
    check("t7_rst_stall", 32'(issueStall_o),     32'h0);
    check("t7_rst_busy",  32'(cfgBusy_o),        32'h0);
    #2;
    reset = 1'b1;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (cfgAck_o) acks++;
    end
    check("t7_no_ack",   32'(acks),         32'd0);
    check("t7_lane_end", 32'(laneActive_o), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
